// File: rtl/multicycle_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for an RV32I core sharing one memory port.
// Every datapath control is decoded combinationally from the current state and the IR fields.
module multicycle_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic             branch_taken,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             mem_addr_sel,
  output logic             ir_we,
  output logic             pc_we,
  output logic [1:0]       pc_sel,
  output logic [1:0]       alu_a_sel,
  output logic             alu_b_sel,
  output logic             reg_we,
  output logic [1:0]       wb_sel,
  output logic [2:0]       state,
  output logic             trap,
  output logic [CNT_W-1:0] instret
);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [2:0] {
    S_RESET  = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6,
    S_TRAP   = 3'd7
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_instret;

  logic       w_is_lui, w_is_auipc, w_is_jal, w_is_jalr, w_is_branch;
  logic       w_is_load, w_is_store, w_is_op, w_is_system;
  logic       w_legal;
  logic [1:0] w_alu_a;
  logic       w_alu_b;

  assign w_is_lui    = (opcode == OP_LUI);
  assign w_is_auipc  = (opcode == OP_AUIPC);
  assign w_is_jal    = (opcode == OP_JAL);
  assign w_is_jalr   = (opcode == OP_JALR);
  assign w_is_branch = (opcode == OP_BRANCH);
  assign w_is_load   = (opcode == OP_LOAD);
  assign w_is_store  = (opcode == OP_STORE);
  assign w_is_op     = (opcode == OP_OP);
  assign w_is_system = (opcode == OP_SYSTEM);

  // Operand selects are a pure function of the opcode so they hold steady across EXEC, MEM and WB.
  assign w_alu_a = (w_is_auipc || w_is_jal || w_is_branch) ? 2'd1 :
                   w_is_lui ? 2'd2 : 2'd0;
  assign w_alu_b = !(w_is_op || w_is_branch);

  always_comb begin
    w_legal = 1'b0;
    case (opcode)
      OP_LUI, OP_AUIPC, OP_JAL, OP_OPIMM, OP_OP, OP_SYSTEM: w_legal = 1'b1;
      OP_JALR:   w_legal = (funct3 == 3'b000);
      OP_BRANCH: w_legal = (funct3 != 3'b010) && (funct3 != 3'b011);
      OP_LOAD:   w_legal = (funct3 != 3'b011) && (funct3[2:1] != 2'b11);
      OP_STORE:  w_legal = (funct3 < 3'b011);
      default:   w_legal = 1'b0;
    endcase
  end

  always_comb begin
    w_next       = r_state;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    ir_we        = 1'b0;
    pc_we        = 1'b0;
    pc_sel       = 2'd0;
    alu_a_sel    = 2'd0;
    alu_b_sel    = 1'b0;
    reg_we       = 1'b0;
    wb_sel       = 2'd0;
    trap         = 1'b0;
    case (r_state)
      S_RESET: w_next = S_FETCH;
      S_FETCH: begin
        mem_req = 1'b1;
        ir_we   = mem_ready;
        if (mem_ready) w_next = S_DECODE;
      end
      S_DECODE: begin
        if (!w_legal)         w_next = S_TRAP;
        else if (w_is_system) w_next = S_HALT;
        else                  w_next = S_EXEC;
      end
      S_EXEC: begin
        alu_a_sel = w_alu_a;
        alu_b_sel = w_alu_b;
        if (w_is_branch) begin
          pc_we  = 1'b1;
          pc_sel = branch_taken ? 2'd1 : 2'd0;
          w_next = S_FETCH;
        end else if (w_is_load || w_is_store) begin
          w_next = S_MEM;
        end else begin
          w_next = S_WB;
        end
      end
      S_MEM: begin
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
        mem_we       = w_is_store;
        alu_a_sel    = w_alu_a;
        alu_b_sel    = w_alu_b;
        if (mem_ready) begin
          if (w_is_store) begin
            pc_we  = 1'b1;
            w_next = S_FETCH;
          end else begin
            w_next = S_WB;
          end
        end
      end
      S_WB: begin
        alu_a_sel = w_alu_a;
        alu_b_sel = w_alu_b;
        reg_we    = 1'b1;
        pc_we     = 1'b1;
        wb_sel    = w_is_load ? 2'd1 : (w_is_jal || w_is_jalr) ? 2'd2 : 2'd0;
        pc_sel    = w_is_jal ? 2'd1 : w_is_jalr ? 2'd2 : 2'd0;
        w_next    = S_FETCH;
      end
      S_HALT: w_next = S_HALT;
      S_TRAP: begin
        trap   = 1'b1;
        w_next = S_TRAP;
      end
      default: w_next = S_RESET;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_RESET;
    else     r_state <= w_next;
  end

  // The counter advances on the same edge as the single pc_we pulse of each retired instruction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        r_instret <= '0;
    else if (pc_we) r_instret <= r_instret + CNT_ONE;
  end

  assign state   = r_state;
  assign instret = r_instret;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: cycle-vector table, corner-case sequences, and a randomized
// instruction stream checked against a per-instruction timing/effects model.
module tb_multicycle_ctrl;

  localparam logic [6:0] LUI = 7'h37, AUIPC = 7'h17, JAL = 7'h6F, JALR = 7'h67, BR = 7'h63;
  localparam logic [6:0] LD = 7'h03, ST = 7'h23, OPI = 7'h13, OPR = 7'h33, SYS = 7'h73;

  logic clk = 1'b0;
  logic rst;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic branch_taken, mem_ready;

  logic mem_req, mem_we, mem_addr_sel, ir_we, pc_we, alu_b_sel, reg_we, trap;
  logic [1:0] pc_sel, alu_a_sel, wb_sel;
  logic [2:0] state;
  logic [31:0] instret;

  logic mem_req_b, mem_we_b, mem_addr_sel_b, ir_we_b, pc_we_b, alu_b_sel_b, reg_we_b, trap_b;
  logic [1:0] pc_sel_b, alu_a_sel_b, wb_sel_b;
  logic [2:0] state_b;
  logic [3:0] instret_b;

  multicycle_ctrl #(.CNT_W(32)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .branch_taken(branch_taken),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .mem_addr_sel(mem_addr_sel),
    .ir_we(ir_we), .pc_we(pc_we), .pc_sel(pc_sel), .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel),
    .reg_we(reg_we), .wb_sel(wb_sel), .state(state), .trap(trap), .instret(instret)
  );

  multicycle_ctrl #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .branch_taken(branch_taken),
    .mem_ready(mem_ready), .mem_req(mem_req_b), .mem_we(mem_we_b), .mem_addr_sel(mem_addr_sel_b),
    .ir_we(ir_we_b), .pc_we(pc_we_b), .pc_sel(pc_sel_b), .alu_a_sel(alu_a_sel_b),
    .alu_b_sel(alu_b_sel_b), .reg_we(reg_we_b), .wb_sel(wb_sel_b), .state(state_b),
    .trap(trap_b), .instret(instret_b)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int unsigned m_cnt = 0;

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s [%0d] got %0h want %0h", name, idx, act, exp);
    end
  endtask

  typedef struct {
    logic [6:0] op; logic [2:0] f3; logic bt; logic rdy;
    logic [2:0] st; logic req; logic we; logic asel; logic irwe; logic pcwe;
    logic [1:0] ps; logic [1:0] aa; logic ab; logic rw; logic [1:0] wb; logic tr; int cnt;
  } vec_t;
  vec_t tv[$];

  // Argument order: inputs (op f3 bt rdy) | st req we asel irwe pcwe ps aa ab rw wb tr cnt
  function automatic void row(input logic [6:0] op, input logic [2:0] f3, input logic bt,
      input logic rdy, input logic [2:0] st, input logic req, input logic we, input logic asel,
      input logic irwe, input logic pcwe, input logic [1:0] ps, input logic [1:0] aa,
      input logic ab, input logic rw, input logic [1:0] wb, input logic tr, input int cnt);
    vec_t v;
    v.op = op; v.f3 = f3; v.bt = bt; v.rdy = rdy; v.st = st; v.req = req; v.we = we;
    v.asel = asel; v.irwe = irwe; v.pcwe = pcwe; v.ps = ps; v.aa = aa; v.ab = ab;
    v.rw = rw; v.wb = wb; v.tr = tr; v.cnt = cnt;
    tv.push_back(v);
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    mem_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    m_cnt = 0;
  endtask

  task automatic chk_idle(input string name, input int idx);
    chk({name, "_pc_we"}, idx, pc_we, 1'b0);
    chk({name, "_reg_we"}, idx, reg_we, 1'b0);
    chk({name, "_mem_req"}, idx, mem_req, 1'b0);
    chk({name, "_ir_we"}, idx, ir_we, 1'b0);
    chk({name, "_mem_we"}, idx, mem_we, 1'b0);
  endtask

  task automatic trap_seq(input logic [6:0] op, input logic [2:0] f3, input int idx);
    do_reset();
    opcode = op; funct3 = f3; mem_ready = 1'b1; branch_taken = 1'b0;
    @(negedge clk); #1 chk("trap_fetch", idx, state, 3'd1);
    @(negedge clk); #1 chk("trap_decode", idx, state, 3'd2);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1;
      chk("trap_state", idx, state, 3'd7);
      chk("trap_out", idx, trap, 1'b1);
      chk_idle("trap", idx);
    end
  endtask

  // Reference model: legality, per-class cycle cost and side effects from the instruction rules.
  function automatic bit m_legal(input logic [6:0] op, input logic [2:0] f3);
    case (op)
      LUI, AUIPC, JAL, OPI, OPR, SYS: return 1'b1;
      JALR: return f3 == 3'd0;
      BR:   return !(f3 inside {3'd2, 3'd3});
      LD:   return !(f3 inside {3'd3, 3'd6, 3'd7});
      ST:   return f3 <= 3'd2;
      default: return 1'b0;
    endcase
  endfunction

  logic [6:0] op_list [13] = '{LUI, AUIPC, JAL, JALR, BR, LD, ST, OPI, OPR, SYS, 7'h00, 7'h7F, 7'h0F};

  task automatic run_one(input int idx);
    logic [6:0] op; logic [2:0] f3; logic bt;
    int fw, mw, cyc, fetch_n, mem_n, pcwe_n, regwe_n, mwe_n, irwe_n, exp_cyc, kind;
    logic [1:0] ps_seen, wb_seen, exp_ps, exp_wb;
    bit done;
    op = op_list[$urandom_range(0, 12)];
    f3 = 3'($urandom_range(0, 7));
    bt = 1'($urandom_range(0, 1));
    fw = $urandom_range(0, 3);
    mw = $urandom_range(0, 3);
    kind = !m_legal(op, f3) ? 2 : (op == SYS) ? 1 : 0;
    cyc = 0; fetch_n = 0; mem_n = 0; pcwe_n = 0; regwe_n = 0; mwe_n = 0; irwe_n = 0;
    ps_seen = 2'd0; wb_seen = 2'd0; done = 1'b0;
    opcode = op; funct3 = f3; branch_taken = bt;
    while (!done && cyc < 40) begin
      mem_ready = 1'b0;
      #1;
      if (mem_req && !mem_addr_sel) begin mem_ready = (fetch_n == fw); fetch_n++; end
      else if (mem_req)             begin mem_ready = (mem_n == mw);   mem_n++;   end
      else                          mem_ready = 1'($urandom_range(0, 1));
      #1;
      if (pc_we)  begin pcwe_n++;  ps_seen = pc_sel; end
      if (reg_we) begin regwe_n++; wb_seen = wb_sel; end
      if (mem_we && mem_req) mwe_n++;
      if (ir_we) irwe_n++;
      cyc++;
      if (kind == 0 && pc_we) done = 1'b1;
      if (kind != 0 && (state == 3'd6 || state == 3'd7)) done = 1'b1;
      @(negedge clk);
    end
    chk("rand_done", idx, done, 1'b1);
    if (kind == 0) begin
      exp_cyc = fw + ((op == BR) ? 3 : (op == LD) ? 5 : 4) + ((op == LD || op == ST) ? mw : 0);
      exp_ps  = (op == BR) ? {1'b0, bt} : (op == JAL) ? 2'd1 : (op == JALR) ? 2'd2 : 2'd0;
      exp_wb  = (op == LD) ? 2'd1 : (op == JAL || op == JALR) ? 2'd2 : 2'd0;
      m_cnt++;
      chk("rand_cycles", idx, cyc, exp_cyc);
      chk("rand_pc_we_n", idx, pcwe_n, 1);
      chk("rand_reg_we_n", idx, regwe_n, (op == BR || op == ST) ? 0 : 1);
      chk("rand_mem_we_n", idx, mwe_n, (op == ST) ? mw + 1 : 0);
      chk("rand_ir_we_n", idx, irwe_n, 1);
      chk("rand_pc_sel", idx, ps_seen, exp_ps);
      if (regwe_n != 0) chk("rand_wb_sel", idx, wb_seen, exp_wb);
      chk("rand_instret", idx, instret, m_cnt);
      chk("rand_instret4", idx, instret_b, m_cnt % 16);
      chk("rand_next_fetch", idx, state, 3'd1);
    end else begin
      chk("rand_term_cycles", idx, cyc, fw + 3);
      chk("rand_term_state", idx, state, (kind == 2) ? 3'd7 : 3'd6);
      chk("rand_term_trap", idx, trap, kind == 2);
      chk("rand_term_pc_we", idx, pcwe_n, 0);
      chk("rand_term_reg_we", idx, regwe_n, 0);
      chk("rand_term_instret", idx, instret, m_cnt);
      do_reset();
      @(negedge clk);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog time_limit got running want finished");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; opcode = '0; funct3 = '0; branch_taken = 1'b0; mem_ready = 1'b0;

    row(OPI,0,0,1, 0,0,0,0,0,0,0,0,0,0,0,0,0);
    row(OPI,0,0,1, 1,1,0,0,1,0,0,0,0,0,0,0,0);
    row(OPI,0,0,1, 2,0,0,0,0,0,0,0,0,0,0,0,0);
    row(OPI,0,0,1, 3,0,0,0,0,0,0,0,1,0,0,0,0);
    row(OPI,0,0,1, 5,0,0,0,0,1,0,0,1,1,0,0,0);
    row(LD, 2,0,0, 1,1,0,0,0,0,0,0,0,0,0,0,1);
    row(LD, 2,0,0, 1,1,0,0,0,0,0,0,0,0,0,0,1);
    row(LD, 2,0,1, 1,1,0,0,1,0,0,0,0,0,0,0,1);
    row(LD, 2,0,0, 2,0,0,0,0,0,0,0,0,0,0,0,1);
    row(LD, 2,0,0, 3,0,0,0,0,0,0,0,1,0,0,0,1);
    row(LD, 2,0,0, 4,1,0,1,0,0,0,0,1,0,0,0,1);
    row(LD, 2,0,0, 4,1,0,1,0,0,0,0,1,0,0,0,1);
    row(LD, 2,0,1, 4,1,0,1,0,0,0,0,1,0,0,0,1);
    row(LD, 2,0,1, 5,0,0,0,0,1,0,0,1,1,1,0,1);
    row(BR, 0,1,1, 1,1,0,0,1,0,0,0,0,0,0,0,2);
    row(BR, 0,1,1, 2,0,0,0,0,0,0,0,0,0,0,0,2);
    row(BR, 0,1,1, 3,0,0,0,0,1,1,1,0,0,0,0,2);
    row(BR, 0,0,1, 1,1,0,0,1,0,0,0,0,0,0,0,3);
    row(BR, 0,0,1, 2,0,0,0,0,0,0,0,0,0,0,0,3);
    row(BR, 0,0,1, 3,0,0,0,0,1,0,1,0,0,0,0,3);
    row(JAL,0,0,1, 1,1,0,0,1,0,0,0,0,0,0,0,4);
    row(JAL,0,0,1, 2,0,0,0,0,0,0,0,0,0,0,0,4);
    row(JAL,0,0,1, 3,0,0,0,0,0,0,1,1,0,0,0,4);
    row(JAL,0,0,1, 5,0,0,0,0,1,1,1,1,1,2,0,4);
    row(ST, 2,0,1, 1,1,0,0,1,0,0,0,0,0,0,0,5);
    row(ST, 2,0,1, 2,0,0,0,0,0,0,0,0,0,0,0,5);
    row(ST, 2,0,1, 3,0,0,0,0,0,0,0,1,0,0,0,5);
    row(ST, 2,0,1, 4,1,1,1,0,1,0,0,1,0,0,0,5);
    row(ST, 2,0,0, 1,1,0,0,0,0,0,0,0,0,0,0,6);

    do_reset();
    for (int i = 0; i < tv.size(); i++) begin
      opcode = tv[i].op; funct3 = tv[i].f3; branch_taken = tv[i].bt; mem_ready = tv[i].rdy;
      #1;
      chk("v_state", i, state, tv[i].st);
      chk("v_mem_req", i, mem_req, tv[i].req);
      chk("v_mem_we", i, mem_we, tv[i].we);
      chk("v_mem_addr_sel", i, mem_addr_sel, tv[i].asel);
      chk("v_ir_we", i, ir_we, tv[i].irwe);
      chk("v_pc_we", i, pc_we, tv[i].pcwe);
      chk("v_pc_sel", i, pc_sel, tv[i].ps);
      chk("v_alu_a_sel", i, alu_a_sel, tv[i].aa);
      chk("v_alu_b_sel", i, alu_b_sel, tv[i].ab);
      chk("v_reg_we", i, reg_we, tv[i].rw);
      chk("v_wb_sel", i, wb_sel, tv[i].wb);
      chk("v_trap", i, trap, tv[i].tr);
      chk("v_instret", i, instret, tv[i].cnt);
      @(negedge clk);
    end

    trap_seq(JALR, 3'd1, 0);
    trap_seq(7'h00, 3'd0, 1);

    // Reset arriving while a store waits in MEM.
    do_reset();
    opcode = OPI; funct3 = 3'd0; mem_ready = 1'b1;
    repeat (5) @(negedge clk);
    opcode = ST; funct3 = 3'd2;
    @(negedge clk);
    @(negedge clk);
    mem_ready = 1'b0;
    @(negedge clk); #1;
    chk("rmem_state", 0, state, 3'd4);
    chk("rmem_req", 0, mem_req, 1'b1);
    chk("rmem_instret", 0, instret, 1);
    rst = 1'b1; #1;
    chk("rmem_req_drop", 0, mem_req, 1'b0);
    chk("rmem_state_rst", 0, state, 3'd0);
    chk("rmem_instret_rst", 0, instret, 0);
    chk("rmem_instret4_rst", 0, instret_b, 0);
    chk_idle("rmem", 0);
    @(posedge clk); #1 chk("rmem_state_hold", 0, state, 3'd0);
    @(negedge clk); rst = 1'b0; #1 chk("rmem_state_rel", 0, state, 3'd0);
    @(negedge clk); #1;
    chk("rmem_fetch", 0, state, 3'd1);
    chk("rmem_fetch_addr", 0, mem_addr_sel, 1'b0);

    // Narrow counter wrap, then ECALL halts with the count frozen.
    do_reset();
    opcode = OPI; funct3 = 3'd0; mem_ready = 1'b1;
    @(negedge clk);
    repeat (17 * 4) @(negedge clk);
    #1;
    chk("wrap_instret4", 0, instret_b, 1);
    chk("wrap_instret32", 0, instret, 17);
    opcode = SYS;
    @(negedge clk);
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      mem_ready = k[0]; branch_taken = k[1]; #1;
      chk("halt_state", k, state, 3'd6);
      chk("halt_trap", k, trap, 1'b0);
      chk_idle("halt", k);
      chk("halt_instret4", k, instret_b, 1);
      chk("halt_instret32", k, instret, 17);
      @(negedge clk);
    end

    do_reset();
    @(negedge clk);
    for (int i = 0; i < 300; i++) run_one(i);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multi-cycle sequencing controller for the RV32I core. It steps each instruction through fetch, decode, execute, memory and writeback. It shares the single memory port between instruction fetch and data access using a req/ready handshake. It drives the enable and mux-select lines of the PC, IR, ALU, register file and writeback path. It takes opcode and funct3 from the instruction decoder's field outputs, which are driven from the IR, and counts retired instructions.

## Interface
- CNT_W, 32, width of retired-instruction counter
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- opcode  in  7  IR[6:0] from decoder, stable from DECODE onward
- funct3  in  3  IR[14:12] from decoder
- branch_taken  in  1  comparator result, sampled in EXEC of a branch only
- mem_ready  in  1  memory completes the pending access this cycle; ignored when mem_req=0
- mem_req  out  1  memory access request, held until mem_ready
- mem_we  out  1  write strobe, qualified by mem_req
- mem_addr_sel  out  1  0=PC, 1=ALU result
- ir_we  out  1  load IR from memory read data
- pc_we  out  1  update PC
- pc_sel  out  2  0=PC+4, 1=PC+imm, 2=ALU result & ~1
- alu_a_sel  out  2  0=rs1, 1=PC, 2=zero
- alu_b_sel  out  1  0=rs2, 1=imm
- reg_we  out  1  register-file write enable
- wb_sel  out  2  0=ALU, 1=memory data, 2=PC+4
- state  out  3  current state, for debug
- trap  out  1  high while in TRAP
- instret  out  CNT_W  retired-instruction count

## Operation
- State encodings: RESET=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6, TRAP=7.
- Async reset: state=RESET and instret=0. In RESET all outputs are 0. RESET always moves to FETCH on the next edge.
- FETCH: mem_req=1, mem_addr_sel=0, mem_we=0.
  - ir_we equals mem_ready.
  - On mem_ready, go to DECODE; otherwise stay.
- DECODE: legality check on opcode/funct3.
  - Legal opcodes: LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111, BRANCH 1100011, LOAD 0000011, STORE 0100011, OP-IMM 0010011, OP 0110011, SYSTEM 1110011.
  - Illegal cases: any other opcode; BRANCH funct3 010 or 011; LOAD funct3 011, 110 or 111; STORE funct3 ≥ 011; JALR funct3 ≠ 000.
  - Illegal goes to TRAP. SYSTEM goes to HALT. Everything else goes to EXEC.
- EXEC: ALU operand selects.
  - alu_a_sel: 1 for AUIPC/JAL/BRANCH-target, 2 for LUI, else 0.
  - alu_b_sel: 0 for OP and BRANCH, else 1.
  - BRANCH: pc_we=1, pc_sel = branch_taken ? 1 : 0, instret increments, go to FETCH.
  - LOAD/STORE go to MEM. All others go to WB.
- MEM: mem_req=1, mem_addr_sel=1, mem_we=1 for STORE. ALU selects are held as in EXEC.
  - On mem_ready, STORE: pc_we=1, pc_sel=0, instret increments, go to FETCH.
  - On mem_ready, LOAD: go to WB.
  - Without mem_ready, stay.
- WB: reg_we=1, pc_we=1, instret increments, go to FETCH.
  - wb_sel = 1 for LOAD, 2 for JAL/JALR, else 0.
  - pc_sel = 1 for JAL, 2 for JALR, else 0.
- HALT and TRAP are terminal until rst. All enables are 0. trap=1 only in TRAP.
- Outputs are a combinational function of state, opcode, funct3, branch_taken and mem_ready. No output depends on mem_ready outside FETCH and MEM.
- instret wraps modulo 2^CNT_W.

## Timing
- CPI with a zero-wait memory (mem_ready=1 whenever requested):
  - BRANCH: 3
  - OP, OP-IMM, LUI, AUIPC, JAL, JALR, STORE: 4
  - LOAD: 5
- Each memory wait cycle adds 1 cycle in FETCH or MEM. The request and all selects stay stable while waiting.
- pc_we is asserted for exactly one cycle per retired instruction. instret updates on that same edge.
- reg_we is never asserted for BRANCH or STORE.
- An async reset at any point, including a pending memory wait, aborts the access: mem_req drops immediately. No reg_we or pc_we is issued. The sequence restarts at RESET, then FETCH.

## Test plan
- ADDI x1,x0,5 (opcode 0010011), mem_ready tied 1:
  - States 1, 2, 3, 5, 1.
  - In WB: reg_we=1, wb_sel=0, pc_sel=0.
  - instret goes 0 to 1.
- LW (0000011, funct3 010) with mem_ready delayed 2 cycles in both FETCH and MEM:
  - Total 9 cycles.
  - mem_addr_sel=0 while waiting in FETCH, 1 while waiting in MEM.
  - wb_sel=1 in WB.
- BEQ (1100011, funct3 000):
  - With branch_taken=1, EXEC has pc_we=1, pc_sel=1 and reg_we=0; 3 cycles total.
  - Repeat with branch_taken=0: pc_sel=0.
- JALR with funct3 001: TRAP in the cycle after DECODE, trap=1, no pc_we. Opcode 0000000 behaves the same.
- rst asserted mid-MEM of an SW with mem_ready=0: mem_req goes 0 asynchronously, instret=0, state=0. FETCH follows one cycle after rst deasserts.
- CNT_W=4: retire 17 ADDIs and check instret=1 after wrap. Then ECALL (1110011) leads to HALT, with instret frozen and all enables 0.
